// File: rtl/aes_pkg.sv
// Shared state type, block geometry and default timeout for the AES stream adapter.
package aes_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int DEFAULT_TIMEOUT = 64;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [31:0] blockWord(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] word;
    case (idx)
      2'd0:    word = blk[127:96];
      2'd1:    word = blk[95:64];
      2'd2:    word = blk[63:32];
      default: word = blk[31:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/aes_stream_adapter.sv
// Packs four 32-bit stream words into a 128-bit AES core block, runs the core once,
// and streams the 128-bit result back out as four words with a WAIT-state timeout.
module aes_stream_adapter
  import aes_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_enc_dec,
  input  logic [1:0]        in_mode,
  output logic              core_start,
  output logic              core_enc_dec,
  output logic [1:0]        core_mode,
  output logic [127:0]      core_data_in,
  input  logic [127:0]      core_data_out,
  input  logic              core_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLOCK - 1);

  state_t        r_state;
  logic [1:0]    r_inCnt;
  logic [1:0]    r_outCnt;
  logic [TW-1:0] r_timer;
  logic [127:0]  r_block;
  logic [127:0]  r_result;
  logic          r_encDec;
  logic [1:0]    r_mode;
  logic          r_err;

  logic w_inFire;
  logic w_outFire;

  // Handshake strobes and stream outputs are decoded straight from registered state.
  assign in_ready     = (r_state == LOAD);
  assign out_valid    = (r_state == DRAIN);
  assign core_start   = (r_state == START);
  assign w_inFire     = in_valid && in_ready;
  assign w_outFire    = out_valid && out_ready;
  assign out_data     = blockWord(r_result, r_outCnt);
  assign out_last     = out_valid && (r_outCnt == LAST_IDX);
  assign core_data_in = r_block;
  assign core_enc_dec = r_encDec;
  assign core_mode    = r_mode;
  assign err          = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_inCnt  <= 2'd0;
      r_outCnt <= 2'd0;
      r_timer  <= '0;
      r_block  <= '0;
      r_result <= '0;
      r_encDec <= 1'b0;
      r_mode   <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_inFire) begin
            // Shifting left leaves word 0 in the top 32 bits after four transfers.
            r_block <= {r_block[127-WORD_W:0], in_data};
            if (r_inCnt == 2'd0) begin
              r_encDec <= in_enc_dec;
              r_mode   <= in_mode;
            end
            r_inCnt <= r_inCnt + 2'd1;
            if (r_inCnt == LAST_IDX) r_state <= START;
          end
        end
        START: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // A done in the final allowed cycle still wins over the timeout.
          if (core_done) begin
            r_result <= core_data_out;
            r_state  <= DRAIN;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= LOAD;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DRAIN: begin
          if (w_outFire) begin
            r_outCnt <= r_outCnt + 2'd1;
            if (r_outCnt == LAST_IDX) r_state <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed self-checking bench for aes_stream_adapter: packing, core handshake,
// stalled draining, timeout recovery and reset during WAIT.
module tb_aes_stream_adapter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [31:0]  inData = '0;
  logic         inEncDec = 1'b0;
  logic [1:0]   inMode = '0;
  logic         coreStart;
  logic         coreEncDec;
  logic [1:0]   coreMode;
  logic [127:0] coreDataIn;
  logic [127:0] coreDataOut = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
  logic         coreDone = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [31:0]  outData;
  logic         outLast;
  logic         errFlag;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [127:0] JUNK   = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
  localparam logic [127:0] BLK_A  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] RES_A  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BLK_B  = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] RES_B  = 128'hcafef00d_12345678_9abcdef0_0badc0de;

  aes_stream_adapter #(.TIMEOUT(64), .WORD_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_data      (inData),
    .in_enc_dec   (inEncDec),
    .in_mode      (inMode),
    .core_start   (coreStart),
    .core_enc_dec (coreEncDec),
    .core_mode    (coreMode),
    .core_data_in (coreDataIn),
    .core_data_out(coreDataOut),
    .core_done    (coreDone),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_data     (outData),
    .out_last     (outLast),
    .err          (errFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word 0 carries the requested mode/direction; later words carry inverted values
  // so that capturing on the wrong word shows up at the core.
  task automatic applyStimulus(input logic [127:0] blk, input logic encDec0, input logic [1:0] mode0);
    for (int i = 0; i < 4; i++) begin
      int guard = 0;
      while (!inReady && guard < 200) begin
        tick();
        guard++;
      end
      if (!inReady) begin
        checkOutput("inReadyWait", 128'(inReady), 128'(1'b1));
        inValid = 1'b0;
        return;
      end
      inValid  = 1'b1;
      inData   = blk[127-32*i -: 32];
      inEncDec = (i == 0) ? encDec0 : ~encDec0;
      inMode   = (i == 0) ? mode0 : ~mode0;
      tick();
    end
    inValid = 1'b0;
    inData  = '0;
  endtask

  task automatic coreRespond(input int latency, input logic [127:0] result);
    repeat (latency) tick();
    coreDone    = 1'b1;
    coreDataOut = result;
    tick();
    coreDone    = 1'b0;
    coreDataOut = JUNK;
  endtask

  // Pattern 1,0,0,1 on out_ready when stalling; words must arrive once, in order.
  task automatic drainBlock(input logic [127:0] expBlk, input bit useStall);
    int k = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] heldData = '0;
    logic heldLast = 1'b0;
    while (k < 4 && cyc < 200) begin
      if (useStall) outReady = (cyc % 4 == 0) || (cyc % 4 == 3);
      else outReady = 1'b1;
      if (outValid) begin
        if (stalled) begin
          checkOutput("stallHoldData", 128'(outData), 128'(heldData));
          checkOutput("stallHoldLast", 128'(outLast), 128'(heldLast));
        end
        checkOutput("inReadyInDrain", 128'(inReady), 128'(1'b0));
        if (outReady) begin
          checkOutput($sformatf("outWord%0d", k), 128'(outData), 128'(expBlk[127-32*k -: 32]));
          checkOutput($sformatf("outLast%0d", k), 128'(outLast), 128'(k == 3));
          k++;
          stalled = 0;
        end else begin
          heldData = outData;
          heldLast = outLast;
          stalled  = 1;
        end
      end
      tick();
      cyc++;
    end
    outReady = 1'b0;
    if (k < 4) checkOutput("drainWordCount", 128'(k), 128'(4));
    checkOutput("outValidAfterDrain", 128'(outValid), 128'(1'b0));
    checkOutput("inReadyAfterDrain", 128'(inReady), 128'(1'b1));
  endtask

  initial begin
    bit sawValid;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    checkOutput("rstInReady", 128'(inReady), 128'(1'b1));
    checkOutput("rstCoreStart", 128'(coreStart), 128'(1'b0));
    checkOutput("rstOutValid", 128'(outValid), 128'(1'b0));
    checkOutput("rstOutLast", 128'(outLast), 128'(1'b0));
    checkOutput("rstErr", 128'(errFlag), 128'(1'b0));
    checkOutput("rstOutData", 128'(outData), 128'(32'h0));
    checkOutput("rstCoreDataIn", coreDataIn, 128'h0);
    checkOutput("rstCoreMode", 128'(coreMode), 128'(2'b00));
    checkOutput("rstCoreEncDec", 128'(coreEncDec), 128'(1'b0));

    // Block A, with a spurious core_done in the START cycle
    applyStimulus(BLK_A, 1'b0, 2'b00);
    checkOutput("aCoreStart", 128'(coreStart), 128'(1'b1));
    checkOutput("aCoreDataIn", coreDataIn, BLK_A);
    checkOutput("aCoreMode", 128'(coreMode), 128'(2'b00));
    checkOutput("aCoreEncDec", 128'(coreEncDec), 128'(1'b0));
    checkOutput("aInReadyStart", 128'(inReady), 128'(1'b0));
    coreDone    = 1'b1;
    coreDataOut = JUNK;
    tick();
    coreDone = 1'b0;
    checkOutput("aStartPulseOnce", 128'(coreStart), 128'(1'b0));
    checkOutput("aDoneInStartIgnored", 128'(outValid), 128'(1'b0));
    checkOutput("aHoldDataIn", coreDataIn, BLK_A);
    coreRespond(3, RES_A);
    checkOutput("aHoldDataInDrain", coreDataIn, BLK_A);
    drainBlock(RES_A, 1'b1);

    // Timeout: no core_done for 64 WAIT cycles
    applyStimulus(BLK_B, 1'b0, 2'b01);
    sawValid = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (outValid) sawValid = 1;
    end
    checkOutput("toErrBeforeLimit", 128'(errFlag), 128'(1'b0));
    checkOutput("toInReadyBeforeLimit", 128'(inReady), 128'(1'b0));
    tick();
    if (outValid) sawValid = 1;
    checkOutput("toErrSet", 128'(errFlag), 128'(1'b1));
    checkOutput("toBackToLoad", 128'(inReady), 128'(1'b1));
    checkOutput("toNoOutValid", 128'(sawValid), 128'(1'b0));

    // Normal block after timeout; mode/direction taken from word 0 only
    applyStimulus(BLK_B, 1'b1, 2'b10);
    checkOutput("bCoreStart", 128'(coreStart), 128'(1'b1));
    checkOutput("bCoreDataIn", coreDataIn, BLK_B);
    checkOutput("bCoreMode", 128'(coreMode), 128'(2'b10));
    checkOutput("bCoreEncDec", 128'(coreEncDec), 128'(1'b1));
    tick();
    coreRespond(0, RES_B);
    drainBlock(RES_B, 1'b0);
    checkOutput("bErrSticky", 128'(errFlag), 128'(1'b1));

    // Reset while in WAIT, followed by a late core_done
    applyStimulus(BLK_A, 1'b0, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("wrInReady", 128'(inReady), 128'(1'b1));
    checkOutput("wrOutValid", 128'(outValid), 128'(1'b0));
    checkOutput("wrErrCleared", 128'(errFlag), 128'(1'b0));
    checkOutput("wrCoreStart", 128'(coreStart), 128'(1'b0));
    checkOutput("wrCoreDataIn", coreDataIn, 128'h0);
    coreRespond(0, RES_A);
    checkOutput("wrLateDoneValid", 128'(outValid), 128'(1'b0));
    checkOutput("wrLateDoneReady", 128'(inReady), 128'(1'b1));

    // Recovery block after reset
    applyStimulus(BLK_A, 1'b0, 2'b00);
    checkOutput("cCoreDataIn", coreDataIn, BLK_A);
    tick();
    coreRespond(1, RES_A);
    drainBlock(RES_A, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/aes_stream_adapter.md
AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles spent in WAIT before the block is abandoned.
REQ-002 SHALL have parameter WORD_W, default 32, meaning stream word width; only 32 is supported.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 in_valid  in  1  upstream word valid.
REQ-006 in_ready  out  1  adapter accepts word.
REQ-007 in_data  in  32  input word; word 0 carries block bits [127:96].
REQ-008 in_enc_dec  in  1  1 = decipher, 0 = encipher; sampled with word 0.
REQ-009 in_mode  in  2  key-size mode; sampled with word 0.
REQ-010 core_start  out  1  one-cycle start pulse to the AES core.
REQ-011 core_enc_dec  out  1  registered direction to the core.
REQ-012 core_mode  out  2  registered mode to the core.
REQ-013 core_data_in  out  128  assembled block to the core.
REQ-014 core_data_out  in  128  core result; valid only in the cycle core_done=1.
REQ-015 core_done  in  1  core completion strobe.
REQ-016 out_valid  out  1  result word valid.
REQ-017 out_ready  in  1  downstream accepts word.
REQ-018 out_data  out  32  result word; word 0 = result bits [127:96].
REQ-019 out_last  out  1  high with result word 3.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 FSM states SHALL be LOAD, START, WAIT and DRAIN.
- LOAD -> START after word 3 is accepted.
- START -> WAIT unconditionally.
- WAIT -> DRAIN on core_done.
- DRAIN -> LOAD after word 3 is accepted.
REQ-022 A transfer SHALL occur only when valid and ready are both 1 in the same cycle.
REQ-023 in_ready SHALL be 1 only in LOAD.
REQ-024 Word counters SHALL be 2 bits and wrap 3 -> 0.
REQ-025 core_enc_dec and core_mode SHALL be captured on the word 0 transfer.
REQ-026 core_data_in, core_enc_dec and core_mode SHALL be held stable from START through DRAIN.
REQ-027 core_start SHALL be 1 exactly during START, which is the cycle after the word 3 transfer.
REQ-028 core_done SHALL be ignored outside WAIT, including in the START cycle.
REQ-029 The result SHALL be latched from core_data_out in the core_done cycle, and out_valid SHALL rise the next cycle.
REQ-030 In DRAIN, out_valid SHALL be 1 and words SHALL be emitted in order 0..3.
REQ-031 When out_ready=0, out_data and out_last SHALL hold stable.
REQ-032 A cycle counter SHALL run in WAIT; on reaching TIMEOUT with no core_done:
- err SHALL be set to 1;
- the block SHALL be dropped;
- the FSM SHALL return to LOAD;
- no output words SHALL be emitted.
REQ-033 err SHALL remain 1 until reset; normal operation SHALL continue after a timeout.
REQ-034 Throughput SHALL be one block in flight; minimum latency from word 3 in to word 0 out is core latency + 2 cycles.

Reset
REQ-035 With reset=0 at a clock edge, the following SHALL take these values:
- FSM = LOAD; counters = 0.
- in_ready = 1 on the first cycle after reset.
- core_start = 0; out_valid = 0; out_last = 0; err = 0.
- out_data = 0; core_data_in = 0; core_mode = 0; core_enc_dec = 0.
REQ-036 Reset in any state SHALL abort the block in progress without a core_start pulse or out_valid.

Structure
REQ-037 A shared package aes_pkg SHALL hold the FSM state enum, WORDS_PER_BLOCK=4 and the default TIMEOUT.
REQ-038 Packing, unpacking, counters and FSM SHALL be inline; no sub-module is required.

Verification
REQ-039 Words 00112233/44556677/8899aabb/ccddeeff, in_mode=00, in_enc_dec=0 -> core_data_in=00112233_44556677_8899aabb_ccddeeff, one-cycle core_start the cycle after word 3.
REQ-040 Model core returns 69c4e0d8_6a7b0430_d8cdb780_70b4c55a with core_done -> out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, out_last on the 4th only.
REQ-041 out_ready toggled 1,0,0,1,... during DRAIN -> no word lost or duplicated, outputs stable while stalled, in_ready=0 until word 3 out.
REQ-042 core_done withheld for TIMEOUT=64 cycles -> err=1, no out_valid, next block processed normally, err stays 1.
REQ-043 reset=0 asserted in WAIT -> next cycle in_ready=1, out_valid=0, err=0; a late core_done is ignored.
REQ-044 core_done asserted in the START cycle -> ignored; result latched only on a WAIT-state core_done.
